// File: rtl/clock_period_monitor.sv
// Measures high/low run lengths of a root-synchronous clock-like signal, checks them against
// expected values with a tolerance, counts completed periods and flags a stalled signal.
module clock_period_monitor #(
    parameter int unsigned W           = 16,
    parameter int unsigned SYNC_STAGES = 0
) (
    input  logic          i_rootClk,
    input  logic          i_arst_n,
    input  logic          i_mon,
    input  logic [W-1:0]  i_expHi,
    input  logic [W-1:0]  i_expLo,
    input  logic [W-1:0]  i_tolerance,
    input  logic [W-1:0]  i_timeout,
    input  logic          i_clear,
    output logic [W-1:0]  o_periodHi,
    output logic [W-1:0]  o_periodLo,
    output logic          o_valid,
    output logic [31:0]   o_periods,
    output logic          o_errHi,
    output logic          o_errLo,
    output logic          o_stuck
);

    typedef enum logic [1:0] {StSeek, StHigh, StLow} state_e;

    state_e        state;
    logic          monS;
    logic          prevQ;
    logic          rise;
    logic          fall;
    logic          edgeDet;
    logic [W-1:0]  runCntQ;
    logic [W-1:0]  runCntD;
    logic          firedQ;
    logic          timeoutHit;
    logic          hiViol;
    logic          loViol;

    if (SYNC_STAGES == 0) begin : gNoSync
        assign monS = i_mon;
    end else begin : gSync
        logic [SYNC_STAGES-1:0] syncQ;
        always_ff @(posedge i_rootClk or negedge i_arst_n) begin
            if (!i_arst_n) begin
                syncQ <= '0;
            end else begin
                syncQ[0] <= i_mon;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    syncQ[i] <= syncQ[i-1];
                end
            end
        end
        assign monS = syncQ[SYNC_STAGES-1];
    end

    function automatic logic [W:0] absDiff(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    assign rise    = monS & ~prevQ;
    assign fall    = ~monS & prevQ;
    assign edgeDet = rise | fall;

    // firedQ keeps a saturated counter from re-triggering the stall flag every cycle
    assign timeoutHit = (i_timeout != '0) && (runCntQ == i_timeout) && !firedQ;
    assign hiViol     = absDiff(runCntQ, i_expHi) > {1'b0, i_tolerance};
    assign loViol     = absDiff(runCntQ, i_expLo) > {1'b0, i_tolerance};

    always_comb begin
        runCntD = runCntQ;
        if (edgeDet) begin
            runCntD = '0;
        end else if (runCntQ != '1) begin
            runCntD = runCntQ + 1'b1;
        end
    end

    always_ff @(posedge i_rootClk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            prevQ   <= 1'b0;
            runCntQ <= '0;
            firedQ  <= 1'b0;
        end else begin
            prevQ   <= monS;
            runCntQ <= runCntD;
            firedQ  <= edgeDet ? 1'b0 : (firedQ | timeoutHit);
        end
    end

    always_ff @(posedge i_rootClk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state      <= StSeek;
            o_periodHi <= '0;
            o_periodLo <= '0;
            o_valid    <= 1'b0;
            o_periods  <= '0;
            o_errHi    <= 1'b0;
            o_errLo    <= 1'b0;
            o_stuck    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_clear) begin
                o_errHi   <= 1'b0;
                o_errLo   <= 1'b0;
                o_stuck   <= 1'b0;
                o_periods <= '0;
            end
            // Set conditions below are later assignments, so they win over a same-cycle clear
            if (timeoutHit) begin
                o_stuck <= 1'b1;
                state   <= StSeek;
            end else begin
                unique case (state)
                    StSeek: begin
                        if (rise) state <= StHigh;
                    end
                    StHigh: begin
                        if (fall) begin
                            o_periodHi <= runCntQ;
                            if (hiViol) o_errHi <= 1'b1;
                            state <= StLow;
                        end
                    end
                    StLow: begin
                        if (rise) begin
                            o_periodLo <= runCntQ;
                            if (loViol) o_errLo <= 1'b1;
                            o_valid <= 1'b1;
                            if (i_clear) begin
                                o_periods <= 32'd1;
                            end else if (o_periods != '1) begin
                                o_periods <= o_periods + 32'd1;
                            end
                            state <= StHigh;
                        end
                    end
                    default: state <= StSeek;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_period_monitor.sv
// Randomized and directed bench for clock_period_monitor against a run-length reference model.
module tb_clock_period_monitor;

    localparam int W = 16;
    localparam longint MaxCnt = 65535;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          mon = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  expHi = 16'd3;
    logic [W-1:0]  expLo = 16'd5;
    logic [W-1:0]  tol = 16'd0;
    logic [W-1:0]  tmo = 16'd0;
    logic [W-1:0]  periodHi;
    logic [W-1:0]  periodLo;
    logic          valid;
    logic [31:0]   periods;
    logic          errHi;
    logic          errLo;
    logic          stuck;

    logic          mon4 = 1'b0;
    logic [3:0]    p4Hi;
    logic [3:0]    p4Lo;
    logic          v4;
    logic [31:0]   n4;
    logic          e4Hi;
    logic          e4Lo;
    logic          s4;

    int checks = 0;
    int errors = 0;
    bit cmpEn = 1'b0;
    bit randClr = 1'b0;

    clock_period_monitor #(.W(W), .SYNC_STAGES(0)) dut (
        .i_rootClk(clk), .i_arst_n(rstN), .i_mon(mon), .i_expHi(expHi), .i_expLo(expLo),
        .i_tolerance(tol), .i_timeout(tmo), .i_clear(clr), .o_periodHi(periodHi),
        .o_periodLo(periodLo), .o_valid(valid), .o_periods(periods), .o_errHi(errHi),
        .o_errLo(errLo), .o_stuck(stuck)
    );

    clock_period_monitor #(.W(4), .SYNC_STAGES(0)) dut4 (
        .i_rootClk(clk), .i_arst_n(rstN), .i_mon(mon4), .i_expHi(4'd3), .i_expLo(4'd2),
        .i_tolerance(4'd0), .i_timeout(4'd0), .i_clear(1'b0), .o_periodHi(p4Hi),
        .o_periodLo(p4Lo), .o_valid(v4), .o_periods(n4), .o_errHi(e4Hi), .o_errLo(e4Lo),
        .o_stuck(s4)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the sampled level and samples since the last level change.
    bit     mPrev = 1'b0;
    longint mRun = 0;
    bit     mArmed = 1'b0;
    bit     mHiDone = 1'b0;
    longint mPerHi = 0;
    longint mPerLo = 0;
    bit     mValid = 1'b0;
    longint mPeriods = 0;
    bit     mErrHi = 1'b0;
    bit     mErrLo = 1'b0;
    bit     mStuck = 1'b0;

    function automatic longint absd(input longint a, input longint b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rstN);
        if (!rstN) begin
            mPrev = 0; mRun = 0; mArmed = 0; mHiDone = 0; mPerHi = 0; mPerLo = 0;
            mValid = 0; mPeriods = 0; mErrHi = 0; mErrLo = 0; mStuck = 0;
        end else begin
            bit lvl, chg, hiV, loV, stl;
            longint cnt;
            lvl = mon;
            chg = (lvl != mPrev);
            cnt = (mRun > MaxCnt) ? MaxCnt : mRun;
            hiV = 0; loV = 0; stl = 0;
            mValid = 0;
            if (tmo != 0 && mRun == longint'(tmo)) begin
                stl = 1; mArmed = 0; mHiDone = 0;
            end else if (chg && lvl) begin
                if (mHiDone) begin
                    mPerLo = cnt;
                    loV = absd(cnt, longint'(expLo)) > longint'(tol);
                    mValid = 1;
                end
                mArmed = 1; mHiDone = 0;
            end else if (chg && !lvl && mArmed && !mHiDone) begin
                mPerHi = cnt;
                hiV = absd(cnt, longint'(expHi)) > longint'(tol);
                mHiDone = 1;
            end
            if (clr) begin
                mErrHi = 0; mErrLo = 0; mStuck = 0; mPeriods = 0;
            end
            if (hiV) mErrHi = 1;
            if (loV) mErrLo = 1;
            if (stl) mStuck = 1;
            if (mValid && mPeriods != 64'hFFFF_FFFF) mPeriods = mPeriods + 1;
            mRun = chg ? 0 : mRun + 1;
            mPrev = lvl;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmpEn) begin
            check("periodHi", periodHi, mPerHi);
            check("periodLo", periodLo, mPerLo);
            check("valid", valid, mValid);
            check("periods", periods, mPeriods);
            check("errHi", errHi, mErrHi);
            check("errLo", errLo, mErrLo);
            check("stuck", stuck, mStuck);
        end
    end

    task automatic runLevel(input bit lvl, input int n);
        mon = lvl;
        repeat (n) begin
            clr = randClr && ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        clr = 1'b0;
    endtask

    task automatic genClk(input int hi, input int lo, input int n);
        repeat (n) begin
            runLevel(1'b1, hi + 1);
            runLevel(1'b0, lo + 1);
        end
    endtask

    task automatic measureSpacing();
        int n;
        n = 0;
        while (!valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < 200);
        check("valid_spacing", n, 10);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_periods", periods, 0);
        check("rst_valid", valid, 0);
        check("rst_stuck", stuck, 0);
        rstN = 1'b1;
        cmpEn = 1'b1;
        @(negedge clk);

        // Clean 4-high / 6-low clock
        fork
            genClk(3, 5, 8);
            measureSpacing();
        join
        check("gen_periodHi", periodHi, 3);
        check("gen_periodLo", periodLo, 5);
        check("gen_periods", periods, 7);
        check("gen_errHi", errHi, 0);

        // Tolerance boundary on the high run
        expHi = 16'd1; tol = 16'd1;
        genClk(3, 5, 2);
        check("tol1_errHi", errHi, 1);
        tol = 16'd2;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clear_errHi", errHi, 0);
        genClk(3, 5, 3);
        check("tol2_errHi", errHi, 0);
        expHi = 16'd3; tol = 16'd0;

        // Stall with the signal held high
        tmo = 16'd20;
        begin
            int n;
            n = 0;
            mon = 1'b1;
            while (!stuck && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("stuck_latency", n, 22);
        end
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("stuck_cleared", stuck, 0);
        runLevel(1'b0, 6);
        runLevel(1'b1, 4);
        runLevel(1'b0, 6);
        check("post_stall_no_valid", periods, 0);
        runLevel(1'b1, 4);
        check("post_stall_first", periods, 1);
        tmo = 16'd0;

        // Clear coinciding with a high-run error
        expHi = 16'd1;
        mon = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_vs_err", errHi, 1);
        expHi = 16'd3;
        runLevel(1'b0, 5);
        runLevel(1'b1, 4);
        check("periods_before_clr", periods, 1);
        mon = 1'b0;
        runLevel(1'b0, 5);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_periods", periods, 0);
        check("clr_errHi2", errHi, 0);

        // Saturating 4-bit counter
        repeat (3) @(negedge clk);
        mon4 = 1'b1;
        repeat (40) @(negedge clk);
        mon4 = 1'b0;
        repeat (3) @(negedge clk);
        check("w4_periodHi", p4Hi, 15);
        check("w4_errHi", e4Hi, 1);
        mon4 = 1'b1;
        repeat (2) @(negedge clk);
        check("w4_periodLo", p4Lo, 2);
        check("w4_periods", n4, 1);
        check("w4_errLo", e4Lo, 0);

        // Asynchronous reset while high
        runLevel(1'b1, 2);
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        check("arst_periodHi", periodHi, 0);
        check("arst_periodLo", periodLo, 0);
        check("arst_periods", periods, 0);
        check("arst_errHi", errHi, 0);
        check("arst_valid", valid, 0);
        mon = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        runLevel(1'b0, 3);
        runLevel(1'b1, 4);
        runLevel(1'b0, 6);
        check("arst_no_valid", periods, 0);
        runLevel(1'b1, 4);
        check("arst_first", periods, 1);

        // Randomized runs, expectations and clears
        randClr = 1'b1;
        for (int it = 0; it < 150; it++) begin
            expHi = 16'($urandom_range(0, 12));
            expLo = 16'($urandom_range(0, 12));
            tol = 16'($urandom_range(0, 4));
            tmo = ($urandom_range(0, 1) == 1) ? 16'd40 : 16'd0;
            if ($urandom_range(0, 9) == 0) begin
                runLevel(1'($urandom_range(0, 1)), $urandom_range(50, 60));
            end else begin
                runLevel(1'b1, $urandom_range(1, 12));
                runLevel(1'b0, $urandom_range(1, 12));
            end
        end
        randClr = 1'b0;

        cmpEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
